// File: rtl/fractal_sync_req_arbiter_pkg.sv
// Shared constants and types for the tile-local fractal-sync request arbiter.
package fractal_sync_req_arbiter_pkg;

  localparam int unsigned FSYNC_AGGR_W      = 8;
  localparam int unsigned FSYNC_ID_W        = 8;
  localparam int unsigned FSYNC_ARB_N_REQ   = 3;
  localparam int unsigned FSYNC_ARB_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } fsync_arb_state_e;

  // Watchdog counter width; a disabled watchdog still keeps a 1-bit counter.
  function automatic int unsigned fsync_cnt_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/fractal_sync_req_arbiter_if.sv
// Master-side fractal-sync port: sync request out, wake/error response back.
interface fractal_sync_req_arbiter_if
  import fractal_sync_req_arbiter_pkg::*;
#(
  parameter int unsigned AGGR_W = FSYNC_AGGR_W,
  parameter int unsigned ID_W   = FSYNC_ID_W
) ();

  logic              sync;
  logic [AGGR_W-1:0] aggr;
  logic [ID_W-1:0]   id_req;
  logic              wake;
  logic              error;

  modport master (
    output sync,
    output aggr,
    output id_req,
    input  wake,
    input  error
  );

  modport slave (
    input  sync,
    input  aggr,
    input  id_req,
    output wake,
    output error
  );

endinterface

// File: rtl/fractal_sync_rr_sel.sv
// Round-robin selector: first set pending bit at or after the pointer, wrapping.
module fractal_sync_rr_sel #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] i_pending,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_valid_c,
  output logic [IDX_W-1:0] o_idx_c
);

  logic [IDX_W-1:0] w_j;

  always_comb begin
    o_valid_c = 1'b0;
    o_idx_c   = '0;
    w_j       = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_j = IDX_W'((32'(i_ptr) + k) % N_REQ);
      if (!o_valid_c && i_pending[w_j]) begin
        o_valid_c = 1'b1;
        o_idx_c   = w_j;
      end
    end
  end

endmodule

// File: rtl/fractal_sync_req_arbiter.sv
// Shares one fractal-sync master port among N_REQ requesters, one barrier in
// flight at a time, with round-robin grant and a WAIT watchdog.
module fractal_sync_req_arbiter
  import fractal_sync_req_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ   = FSYNC_ARB_N_REQ,
  parameter int unsigned AGGR_W  = FSYNC_AGGR_W,
  parameter int unsigned ID_W    = FSYNC_ID_W,
  parameter int unsigned TIMEOUT = FSYNC_ARB_TIMEOUT,
  parameter int unsigned CNT_W   = fsync_cnt_width(TIMEOUT)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  input  logic [N_REQ-1:0]              req_sync_i,
  input  logic [N_REQ-1:0][AGGR_W-1:0]  req_aggr_i,
  input  logic [N_REQ-1:0][ID_W-1:0]    req_id_i,
  output logic [N_REQ-1:0]              req_wake_o,
  output logic [N_REQ-1:0]              req_error_o,
  fractal_sync_req_arbiter_if.master    mst,
  output logic                          busy_o
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  fsync_arb_state_e r_state, w_state_nxt;

  logic [N_REQ-1:0]             r_pending;
  logic [N_REQ-1:0][AGGR_W-1:0] r_aggr;
  logic [N_REQ-1:0][ID_W-1:0]   r_id;
  logic [IDX_W-1:0]             r_rr_ptr;
  logic [IDX_W-1:0]             r_owner;
  logic [CNT_W-1:0]             r_cnt;

  logic              r_sync;
  logic [AGGR_W-1:0] r_aggr_o;
  logic [ID_W-1:0]   r_id_o;
  logic [N_REQ-1:0]  r_wake;
  logic [N_REQ-1:0]  r_err;
  logic              r_busy;

  logic              w_rst;
  logic [N_REQ-1:0]  w_take;
  logic [N_REQ-1:0]  w_ovf;
  logic [N_REQ-1:0]  w_owner_oh;
  logic [N_REQ-1:0]  w_pending_nxt;
  logic              w_sel_valid;
  logic [IDX_W-1:0]  w_sel_idx;
  logic              w_timeout;
  logic              w_grant;
  logic              w_release;
  logic              w_resp_wake;
  logic              w_resp_err;

  assign w_rst      = !rst_ni || clear_i;
  assign w_take     = req_sync_i & ~r_pending;
  assign w_ovf      = req_sync_i & r_pending;
  assign w_owner_oh = N_REQ'(1) << r_owner;
  assign w_timeout  = (TIMEOUT != 0) && (r_cnt == TO_LAST);

  // Owner's pending bit is released only as the FSM leaves RESP.
  assign w_pending_nxt = (r_pending & ~(w_release ? w_owner_oh : '0)) | w_take;

  fractal_sync_rr_sel #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_sel (
    .i_pending (r_pending),
    .i_ptr     (r_rr_ptr),
    .o_valid_c (w_sel_valid),
    .o_idx_c   (w_sel_idx)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (w_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and transition strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_release   = 1'b0;
    w_resp_wake = 1'b0;
    w_resp_err  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sel_valid) begin
          w_grant     = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: w_state_nxt = WAIT;
      WAIT: begin
        if (mst.wake || mst.error) begin
          w_resp_wake = mst.wake;
          w_resp_err  = mst.error;
          w_state_nxt = RESP;
        end else if (w_timeout) begin
          w_resp_err  = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        w_release   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request buffers, arbitration bookkeeping and registered outputs.
  always_ff @(posedge clk_i) begin
    if (w_rst) begin
      r_pending <= '0;
      r_aggr    <= '0;
      r_id      <= '0;
      r_rr_ptr  <= '0;
      r_owner   <= '0;
      r_cnt     <= '0;
      r_sync    <= 1'b0;
      r_aggr_o  <= '0;
      r_id_o    <= '0;
      r_wake    <= '0;
      r_err     <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (w_take[i]) begin
          r_aggr[i] <= req_aggr_i[i];
          r_id[i]   <= req_id_i[i];
        end
      end

      if (w_grant) begin
        r_owner <= w_sel_idx;
      end
      if (w_release) begin
        r_rr_ptr <= (r_owner == IDX_W'(N_REQ - 1)) ? '0 : r_owner + IDX_W'(1);
      end

      if (r_state == ISSUE) begin
        r_cnt <= '0;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      r_sync   <= w_grant;
      r_aggr_o <= w_grant ? r_aggr[w_sel_idx] : '0;
      r_id_o   <= w_grant ? r_id[w_sel_idx]   : '0;

      // Overflow and response errors to the same requester merge into one pulse.
      r_wake <= w_resp_wake ? w_owner_oh : '0;
      r_err  <= w_ovf | (w_resp_err ? w_owner_oh : '0);
      r_busy <= (w_state_nxt != IDLE) || (|w_pending_nxt);
    end
  end

  assign mst.sync    = r_sync;
  assign mst.aggr    = r_aggr_o;
  assign mst.id_req  = r_id_o;
  assign req_wake_o  = r_wake;
  assign req_error_o = r_err;
  assign busy_o      = r_busy;

endmodule

// File: tb/tb_fractal_sync_req_arbiter.sv
// Directed self-checking bench for fractal_sync_req_arbiter with an 8-cycle watchdog.
module tb_fractal_sync_req_arbiter;
  import fractal_sync_req_arbiter_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = FSYNC_AGGR_W;
  localparam int unsigned IW = FSYNC_ID_W;
  localparam int unsigned TO = 8;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  clear;
  logic [N-1:0]          req_sync;
  logic [N-1:0][AW-1:0]  req_aggr;
  logic [N-1:0][IW-1:0]  req_id;
  logic [N-1:0]          req_wake;
  logic [N-1:0]          req_error;
  logic                  busy;

  int n_vec = 0;
  int n_err = 0;

  fractal_sync_req_arbiter_if #(.AGGR_W(AW), .ID_W(IW)) mst_if ();

  fractal_sync_req_arbiter #(
    .N_REQ   (N),
    .AGGR_W  (AW),
    .ID_W    (IW),
    .TIMEOUT (TO)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clear),
    .req_sync_i  (req_sync),
    .req_aggr_i  (req_aggr),
    .req_id_i    (req_id),
    .req_wake_o  (req_wake),
    .req_error_o (req_error),
    .mst         (mst_if),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int i, input logic [AW-1:0] a, input logic [IW-1:0] d);
    req_sync[i] = 1'b1;
    req_aggr[i] = a;
    req_id[i]   = d;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_sync"}, 32'(mst_if.sync), 32'h0);
    check({tag, "_aggr"}, 32'(mst_if.aggr), 32'h0);
    check({tag, "_id"},   32'(mst_if.id_req), 32'h0);
    check({tag, "_wake"}, 32'(req_wake), 32'h0);
    check({tag, "_err"},  32'(req_error), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  // Entered in the expected sync_o cycle; returns in the RESP cycle.
  task automatic serve(input string tag, input int owner, input logic [AW-1:0] ea,
                       input logic [IW-1:0] ei, input bit do_wake, input bit do_err,
                       input int lat);
    logic [N-1:0] oh;
    oh = N'(1) << owner;
    check({tag, "_sync"}, 32'(mst_if.sync), 32'h1);
    check({tag, "_aggr"}, 32'(mst_if.aggr), 32'(ea));
    check({tag, "_id"},   32'(mst_if.id_req), 32'(ei));
    repeat (lat) cyc();
    mst_if.wake  = do_wake;
    mst_if.error = do_err;
    cyc();
    mst_if.wake  = 1'b0;
    mst_if.error = 1'b0;
    check({tag, "_rwake"}, 32'(req_wake), do_wake ? 32'(oh) : 32'h0);
    check({tag, "_rerr"},  32'(req_error), do_err ? 32'(oh) : 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not end");
    $fatal(1);
  end

  initial begin
    rst_n        = 1'b0;
    clear        = 1'b0;
    req_sync     = '0;
    req_aggr     = '0;
    req_id       = '0;
    mst_if.wake  = 1'b0;
    mst_if.error = 1'b0;

    // Reset and the cycle after it.
    cyc(); cyc();
    check_quiet("rst");
    rst_n = 1'b1;
    cyc();
    check_quiet("post_rst");

    // Single request: pulse at t, sync at t+2, wake at t+7, req_wake at t+8.
    pulse(0, AW'(3), IW'(2));
    cyc();
    req_sync = '0;
    check("single_busy", 32'(busy), 32'h1);
    check("single_nosync", 32'(mst_if.sync), 32'h0);
    cyc();
    serve("single", 0, AW'(3), IW'(2), 1'b1, 1'b0, 5);
    check("single_busy_resp", 32'(busy), 32'h1);
    cyc();
    check("single_idle", 32'(busy), 32'h0);
    check("single_wake_once", 32'(req_wake), 32'h0);

    // Soft clear restores rr_ptr to 0.
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    check("clear_busy", 32'(busy), 32'h0);

    // Simultaneous requests granted 0, 1, 2.
    pulse(0, AW'(8'h10), IW'(8'h20));
    pulse(1, AW'(8'h11), IW'(8'h21));
    pulse(2, AW'(8'h12), IW'(8'h22));
    cyc();
    req_sync = '0;
    cyc();
    serve("sim0", 0, AW'(8'h10), IW'(8'h20), 1'b1, 1'b0, 4);
    cyc(); cyc();
    serve("sim1", 1, AW'(8'h11), IW'(8'h21), 1'b1, 1'b0, 4);
    cyc(); cyc();
    serve("sim2", 2, AW'(8'h12), IW'(8'h22), 1'b1, 1'b0, 4);
    cyc();
    check("sim_idle", 32'(busy), 32'h0);

    // req2 then req0: granted 2, 0.
    pulse(2, AW'(8'h32), IW'(8'h42));
    cyc();
    req_sync = '0;
    pulse(0, AW'(8'h30), IW'(8'h40));
    cyc();
    req_sync = '0;
    serve("rr2", 2, AW'(8'h32), IW'(8'h42), 1'b1, 1'b0, 4);
    cyc(); cyc();
    serve("rr0", 0, AW'(8'h30), IW'(8'h40), 1'b1, 1'b0, 4);
    cyc();

    // Overflow: second req1 pulse dropped, error pulse next cycle, first id kept.
    pulse(1, AW'(6), IW'(5));
    cyc();
    pulse(1, AW'(7), IW'(9));
    cyc();
    req_sync = '0;
    check("ovf_err", 32'(req_error), 32'h2);
    serve("ovf", 1, AW'(6), IW'(5), 1'b1, 1'b0, 4);
    cyc();
    check("ovf_idle", 32'(busy), 32'h0);
    check("ovf_err_clr", 32'(req_error), 32'h0);
    cyc();
    check("ovf_one_sync", 32'(mst_if.sync), 32'h0);

    // Timeout on owner 2 (rr_ptr=2), then owner 0 gets wake+error together.
    pulse(0, AW'(1), IW'(1));
    pulse(2, AW'(2), IW'(2));
    cyc();
    req_sync = '0;
    cyc();
    check("to_sync", 32'(mst_if.sync), 32'h1);
    check("to_id", 32'(mst_if.id_req), 32'h2);
    repeat (8) cyc();
    check("to_early", 32'(req_error), 32'h0);
    cyc();
    check("to_err", 32'(req_error), 32'h4);
    check("to_nowake", 32'(req_wake), 32'h0);
    cyc();
    check("to_err_clr", 32'(req_error), 32'h0);
    cyc();
    serve("neterr", 0, AW'(1), IW'(1), 1'b1, 1'b1, 4);
    cyc();
    check("neterr_idle", 32'(busy), 32'h0);

    // Reset mid-WAIT, then a stray wake is ignored.
    pulse(1, AW'(4), IW'(4));
    cyc();
    req_sync = '0;
    cyc();
    check("rw_sync", 32'(mst_if.sync), 32'h1);
    cyc();
    rst_n = 1'b0;
    cyc();
    check_quiet("rw_rst");
    rst_n = 1'b1;
    cyc();
    check_quiet("rw_post");
    mst_if.wake = 1'b1;
    cyc();
    mst_if.wake = 1'b0;
    check("rw_nowake", 32'(req_wake), 32'h0);
    check("rw_nosync", 32'(mst_if.sync), 32'h0);
    check("rw_idle", 32'(busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fractal_sync_req_arbiter.md
Name: fractal_sync_req_arbiter

Overview:
- Shares one fractal-sync master port (tree or neighbour direction) among N_REQ tile-local requesters, e.g. the Xif sync decoder, iDMA and RedMulE event hooks.
- Captures single-cycle sync pulses, grants round-robin with exactly one barrier outstanding at a time, and routes the returning wake or error pulse back to the owning requester.
- Adds a watchdog timeout so that a barrier that never wakes does not hang a tile.

Parameters:
- N_REQ, 3, number of requesters (≥2)
- AGGR_W, magia_tile_pkg::FSYNC_AGGR_W, aggregation-pattern width
- ID_W, magia_tile_pkg::FSYNC_ID_W, barrier id width
- TIMEOUT, 1024, cycles in WAIT before a timeout error; 0 disables the watchdog
- CNT_W, $clog2(TIMEOUT+1) (min 1), watchdog counter width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- clear_i  in  1  synchronous soft clear, same effect as reset
- req_sync_i  in  N_REQ  one-cycle sync request pulse per requester
- req_aggr_i  in  N_REQ×AGGR_W  aggregation pattern, valid with the pulse
- req_id_i  in  N_REQ×ID_W  barrier id, valid with the pulse
- req_wake_o  out  N_REQ  one-cycle completion pulse to the owner
- req_error_o  out  N_REQ  one-cycle error pulse (network error, timeout, overflow)
- sync_o  out  1  master sync pulse
- aggr_o  out  AGGR_W  master aggregation pattern
- id_req_o  out  ID_W  master barrier id
- wake_i  in  1  master wake
- error_i  in  1  master error
- busy_o  out  1  high when not in IDLE or any request is pending

Behaviour:
- Reset / clear_i (sampled at a clock edge): state=IDLE, pending=0, rr_ptr=0, counter=0, latched aggr/id=0. All outputs are 0 during reset and in the cycle after it.
- Per requester i: a req_sync_i[i] pulse while pending[i]=0 sets pending[i] and latches aggr/id[i] at the next edge.
- A pulse while pending[i]=1 is an overflow: the pulse is dropped, buffers are unchanged, and req_error_o[i] pulses the next cycle.
- FSM is IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE: if any pending bit is set, select the first set bit at or after rr_ptr (wrap-around), register it as owner, go to ISSUE.
- ISSUE: sync_o=1 for exactly one cycle with the owner's latched aggr/id; counter cleared; go to WAIT. sync_o, aggr_o and id_req_o are 0 in every other state.
- WAIT: when wake_i or error_i is sampled high, go to RESP and record which one(s) arrived.
- WAIT, watchdog: when TIMEOUT≠0 and the counter reaches TIMEOUT-1 with no wake or error, go to RESP flagged as an error.
- RESP: pulse req_wake_o[owner] if wake was recorded and req_error_o[owner] if error or timeout was recorded; both may pulse together. Clear pending[owner], set rr_ptr=(owner+1) mod N_REQ, return to IDLE.
- Latency: a pulse at cycle t gives sync_o at t+2 when the arbiter is idle. A wake at cycle w gives req_wake_o at w+1.
- wake_i and error_i outside WAIT are ignored.
- A new pulse from the owner while it is in service is an overflow (its pending bit is still set).
- A pulse from a non-owner in the RESP cycle is captured normally.
- An overflow error pulse and a RESP error pulse to the same requester in the same cycle merge into a single pulse.

Decomposition:
- magia_tile_pkg gains FSYNC_ARB_N_REQ, FSYNC_ARB_TIMEOUT and the typedef fsync_arb_state_e {IDLE, ISSUE, WAIT, RESP}.
- One sub-module, fractal_sync_rr_sel: combinational round-robin first-set-bit selector (pending, rr_ptr → valid, idx).
- Instantiate one arbiter per fractal-sync port; the wrapper adapts to fractal_sync_if.

Test Plan:
- Single request: req0 pulses at t=5 with aggr=3, id=2 → sync_o at t=7 with aggr_o=3, id_req_o=2; wake_i at t=12 → req_wake_o[0] at t=13; busy_o low from t=14.
- Simultaneous requests: req0, req1, req2 pulse at the same cycle, each wake returned 4 cycles after its sync_o → sync_o order 0, 1, 2; each req_wake_o goes only to its owner; then req2 followed by req0 again is granted in the order 2, 0.
- Overflow: req1 pulses twice, 1 cycle apart, before its grant → one sync_o only; req_error_o[1] pulses the cycle after the second pulse; the latched id keeps the first value.
- Timeout with TIMEOUT=8 and no wake → req_error_o[owner] 8 cycles after entering WAIT, no req_wake_o; the next pending request is then granted.
- Network error: error_i and wake_i high in the same WAIT cycle → req_wake_o and req_error_o of the owner pulse together in the next cycle.
- Reset mid-WAIT: rst_ni low for 1 cycle → all outputs 0, pending cleared; a later wake_i is ignored and no req_wake_o is produced.
